// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg: shared types and helpers for layer_output_sequencer
//   state_t    : sequencer FSM states
//   WORD0      : word slot of the shift register that drives x_out
//   clog2_min1 : index width that never collapses to zero bits
package layer_seq_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int WORD0 = 0;
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/layer_output_sequencer_if.sv
// layer_output_sequencer_if: parallel-in / serial-out bus of the layer sequencer
//   master : producing-layer side and next-layer consumer (drives o_valid, x_in, clr_err)
//   slave  : sequencer side (drives x_valid, x_out, busy, done, overrun, skew_err)
//   LAYER_SEQ_ARGMAX_EN adds max_idx / max_valid
interface layer_output_sequencer_if import layer_seq_pkg::*; #(
  parameter int NN = 10,
  parameter int dataWidth = 16
);
  logic [NN-1:0] o_valid;
  logic [NN*dataWidth-1:0] x_in;
  logic clr_err;
  logic x_valid;
  logic [dataWidth-1:0] x_out;
  logic busy;
  logic done;
  logic overrun;
  logic skew_err;
`ifdef LAYER_SEQ_ARGMAX_EN
  localparam int IDX_W = clog2_min1(NN);
  logic [IDX_W-1:0] max_idx;
  logic max_valid;
  modport master (output o_valid, x_in, clr_err,
                  input x_valid, x_out, busy, done, overrun, skew_err, max_idx, max_valid);
  modport slave (input o_valid, x_in, clr_err,
                 output x_valid, x_out, busy, done, overrun, skew_err, max_idx, max_valid);
`else
  modport master (output o_valid, x_in, clr_err,
                  input x_valid, x_out, busy, done, overrun, skew_err);
  modport slave (input o_valid, x_in, clr_err,
                 output x_valid, x_out, busy, done, overrun, skew_err);
`endif
endinterface

// File: rtl/seq_argmax.sv
// seq_argmax: running signed argmax over one stream, result pulsed on the last element
//   first/valid/word/idx/last : element to fold into the tracker this cycle
//   max_idx                   : registered index of the maximum, held until the next result
//   max_valid                 : one-cycle pulse the cycle after the last element is folded
module seq_argmax #(
  parameter int DW = 16,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          first,
  input  logic          valid,
  input  logic [DW-1:0] word,
  input  logic [IW-1:0] idx,
  input  logic          last,
  output logic [IW-1:0] max_idx,
  output logic          max_valid
);
  logic signed [DW-1:0] best_q;
  logic [IW-1:0] best_idx_q, max_idx_q;
  logic max_valid_q, take;
  // strict compare keeps the lower index on ties
  assign take = valid && (first || $signed(word) > best_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      best_q <= '0;
      best_idx_q <= '0;
      max_idx_q <= '0;
      max_valid_q <= 1'b0;
    end else begin
      if (take) begin
        best_q <= $signed(word);
        best_idx_q <= idx;
      end
      if (valid && last) max_idx_q <= take ? idx : best_idx_q;
      max_valid_q <= valid && last;
    end
  end
  assign max_idx = max_idx_q;
  assign max_valid = max_valid_q;
endmodule

// File: rtl/layer_output_sequencer.sv
// layer_output_sequencer: captures NN parallel neuron outputs and replays them serially
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave modport (o_valid/x_in/clr_err in; x_valid/x_out/busy/done/overrun/skew_err out)
//   LAYER_SEQ_ARGMAX_EN enables the running argmax (max_idx/max_valid)
module layer_output_sequencer import layer_seq_pkg::*; #(
  parameter int NN = 10,
  parameter int dataWidth = 16
) (
  input logic clk,
  input logic rst,
  layer_output_sequencer_if.slave bus
);
  localparam int IDX_W = clog2_min1(NN);
  state_t state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [NN*dataWidth-1:0] sr_q, sr_d, sr_nx;
  logic ovr_q, ovr_d, skew_q, skew_d;
  logic cap, busy, last, load;
  assign cap = &bus.o_valid;
  assign busy = state_q == SHIFT;
  assign last = cnt_q == IDX_W'(NN - 1);
  // accept from IDLE, or back-to-back on the final word of a stream
  assign load = cap && (!busy || last);
  // register drains to zero, so x_out is 0 whenever nothing is streaming
  assign sr_nx = sr_q >> dataWidth;
  always_comb begin
    state_d = (load || (busy && !last)) ? SHIFT : IDLE;
    cnt_d = load ? '0 : busy ? cnt_q + IDX_W'(1) : cnt_q;
    sr_d = load ? bus.x_in : busy ? sr_nx : sr_q;
    ovr_d = (busy && !last && cap) ? 1'b1 : bus.clr_err ? 1'b0 : ovr_q;
    skew_d = (|bus.o_valid && !cap) ? 1'b1 : bus.clr_err ? 1'b0 : skew_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      ovr_q <= 1'b0;
      skew_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      ovr_q <= ovr_d;
      skew_q <= skew_d;
    end
  end
  assign bus.x_valid = busy;
  assign bus.x_out = sr_q[WORD0*dataWidth +: dataWidth];
  assign bus.busy = busy;
  assign bus.done = busy && last;
  assign bus.overrun = ovr_q;
  assign bus.skew_err = skew_q;
`ifdef LAYER_SEQ_ARGMAX_EN
  // fold each word one cycle before it is emitted so the result lines up with done
  seq_argmax #(.DW(dataWidth), .IW(IDX_W)) u_argmax (
    .clk(clk),
    .rst(rst),
    .first(load),
    .valid(load || (busy && !last)),
    .word(sr_d[WORD0*dataWidth +: dataWidth]),
    .idx(cnt_d),
    .last(load ? (NN == 1) : (cnt_q == IDX_W'(NN - 2))),
    .max_idx(bus.max_idx),
    .max_valid(bus.max_valid)
  );
`endif
endmodule

// File: tb/tb_layer_output_sequencer.sv
// tb_layer_output_sequencer: directed self-checking bench for layer_output_sequencer (NN=4, 16-bit)
module tb_layer_output_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  layer_output_sequencer_if #(.NN(4), .dataWidth(16)) bus ();
  layer_output_sequencer #(.NN(4), .dataWidth(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_xv"}, bus.x_valid, 0);
    chk({tag, "_xout"}, bus.x_out, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask
  task automatic stream(input string tag, input logic [63:0] xin);
    bus.x_in = xin;
    bus.o_valid = 4'hF;
    tick();
    bus.o_valid = 4'h0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_xv%0d", tag, i), bus.x_valid, 1);
      chk($sformatf("%s_xout%0d", tag, i), bus.x_out, xin[i*16 +: 16]);
      chk($sformatf("%s_busy%0d", tag, i), bus.busy, 1);
      chk($sformatf("%s_done%0d", tag, i), bus.done, i == 3);
`ifdef LAYER_SEQ_ARGMAX_EN
      chk($sformatf("%s_mvalid%0d", tag, i), bus.max_valid, i == 3);
`endif
      tick();
    end
    chk_idle({tag, "_end"});
  endtask
  initial begin
    bus.o_valid = '0;
    bus.x_in = '0;
    bus.clr_err = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset_ovr", bus.overrun, 0);
    chk("reset_skew", bus.skew_err, 0);
`ifdef LAYER_SEQ_ARGMAX_EN
    chk("reset_midx", bus.max_idx, 0);
    chk("reset_mvalid", bus.max_valid, 0);
`endif
    rst = 1'b0;
    tick();
    stream("basic", 64'h0004_0003_0002_0001);
    // overrun request at T+2 coinciding with clr_err: set wins
    bus.x_in = 64'h0004_0003_0002_0001;
    bus.o_valid = 4'hF;
    tick();
    bus.o_valid = 4'h0;
    chk("ovr_x1", bus.x_out, 1);
    tick();
    chk("ovr_x2", bus.x_out, 2);
    bus.x_in = 64'h0009_0009_0009_0009;
    bus.o_valid = 4'hF;
    bus.clr_err = 1'b1;
    tick();
    bus.o_valid = 4'h0;
    bus.clr_err = 1'b0;
    chk("ovr_set", bus.overrun, 1);
    chk("ovr_x3", bus.x_out, 3);
    tick();
    chk("ovr_x4", bus.x_out, 4);
    chk("ovr_done", bus.done, 1);
    tick();
    chk_idle("ovr_end");
    tick();
    bus.clr_err = 1'b1;
    chk("ovr_hold", bus.overrun, 1);
    tick();
    bus.clr_err = 1'b0;
    chk("ovr_clr", bus.overrun, 0);
    // back-to-back capture on the last word
    bus.x_in = 64'h0004_0003_0002_0001;
    bus.o_valid = 4'hF;
    tick();
    bus.o_valid = 4'h0;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("b2b_x%0d", i), bus.x_out, i);
      tick();
    end
    bus.x_in = 64'h0008_0007_0006_0005;
    bus.o_valid = 4'hF;
    chk("b2b_x4", bus.x_out, 4);
    chk("b2b_done1", bus.done, 1);
    tick();
    bus.o_valid = 4'h0;
    for (int i = 5; i <= 8; i++) begin
      chk($sformatf("b2b_xv%0d", i), bus.x_valid, 1);
      chk($sformatf("b2b_x%0d", i), bus.x_out, i);
      chk($sformatf("b2b_done%0d", i), bus.done, i == 8);
      tick();
    end
    chk("b2b_ovr", bus.overrun, 0);
    chk_idle("b2b_end");
    // partial valid with simultaneous clr: skew set wins, nothing captured
    bus.x_in = 64'h0004_0003_0002_0001;
    bus.o_valid = 4'b0111;
    bus.clr_err = 1'b1;
    tick();
    bus.o_valid = 4'h0;
    bus.clr_err = 1'b0;
    chk("skew_set", bus.skew_err, 1);
    chk_idle("skew_nocap");
    tick();
    chk_idle("skew_nocap2");
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("skew_clr", bus.skew_err, 0);
    stream("wide", 64'hFFFF_8000_1234_A5A5);
    // reset mid-stream aborts with no done pulse
    bus.x_in = 64'h0004_0003_0002_0001;
    bus.o_valid = 4'hF;
    tick();
    bus.o_valid = 4'h0;
    chk("abort_x1", bus.x_out, 1);
    tick();
    chk("abort_x2", bus.x_out, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("abort_rst");
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_nodone%0d", i), bus.done, 0);
      tick();
    end
    stream("after_rst", 64'h0040_0030_0020_0010);
`ifdef LAYER_SEQ_ARGMAX_EN
    stream("amax_mix", 64'h0002_0007_0007_FFFB);
    chk("amax_mix_idx", bus.max_idx, 1);
    tick();
    chk("amax_mix_hold", bus.max_idx, 1);
    stream("amax_neg", 64'hFFFE_FFF8_FFFF_FFFD);
    chk("amax_neg_idx", bus.max_idx, 1);
    stream("amax_last", 64'h0100_0003_0002_0001);
    chk("amax_last_idx", bus.max_idx, 3);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
